// File: rtl/dbg_uart_loader.sv
// Debug UART loader: turns a small byte-oriented command protocol into
// 32-bit debug memory accesses and controls the CPU reset line.
//   'W' addr[4] data[4] -> word write, replies 'K'
//   'R' addr[4]         -> word read, replies 4 data bytes LSB first
//   'G' / 'H'           -> release / hold the CPU in reset
module dbg_uart_loader #(
    parameter int HOLD_AT_RESET  = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        cpu_n_reset,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    input  logic [31:0] dbg_di
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WRITE,
        READ1,
        READ2,
        SEND
    } state_t;

    localparam logic [31:0] TIMER_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic        is_write;
    logic [31:0] timer;
    logic [23:0] tx_buf;
    logic [1:0]  tx_left;

    // Command parser, memory sequencer and reply sender in one registered FSM.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            is_write    <= 1'b0;
            timer       <= 32'd0;
            tx_buf      <= 24'd0;
            tx_left     <= 2'd0;
            tx_data     <= 8'd0;
            tx_valid    <= 1'b0;
            cpu_n_reset <= (HOLD_AT_RESET == 0);
            dbg_mem_op  <= 1'b0;
            dbg_wren    <= 4'd0;
            dbg_adr     <= 32'd0;
            dbg_do      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            8'h57, 8'h52: begin
                                is_write <= (rx_data == 8'h57);
                                byte_cnt <= 2'd0;
                                timer    <= 32'd0;
                                state    <= ADDR;
                            end
                            8'h47:   cpu_n_reset <= 1'b1;
                            8'h48:   cpu_n_reset <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        timer                            <= 32'd0;
                        dbg_adr[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt                         <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (is_write) begin
                                state <= DATA;
                            end else begin
                                state      <= READ1;
                                dbg_mem_op <= 1'b1;
                                dbg_wren   <= 4'h0;
                            end
                        end
                    end else if (timer == TIMER_LIMIT) begin
                        timer <= 32'd0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        timer                           <= 32'd0;
                        dbg_do[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt                        <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state      <= WRITE;
                            dbg_mem_op <= 1'b1;
                            dbg_wren   <= 4'hF;
                        end
                    end else if (timer == TIMER_LIMIT) begin
                        timer <= 32'd0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                WRITE: begin
                    dbg_mem_op <= 1'b0;
                    dbg_wren   <= 4'h0;
                    tx_data    <= 8'h4B;
                    tx_valid   <= 1'b1;
                    tx_left    <= 2'd0;
                    state      <= SEND;
                end
                READ1: begin
                    state <= READ2;
                end
                READ2: begin
                    dbg_mem_op <= 1'b0;
                    tx_data    <= dbg_di[7:0];
                    tx_buf     <= dbg_di[31:8];
                    tx_left    <= 2'd3;
                    tx_valid   <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (tx_left == 2'd0) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data <= tx_buf[7:0];
                            tx_buf  <= {8'h00, tx_buf[23:8]};
                            tx_left <= tx_left - 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_uart_loader.sv
// Scoreboard bench for dbg_uart_loader: stimulus pushes expected reply bytes
// and memory cycles into queues, a negedge monitor pops and compares them.
module tb_dbg_uart_loader;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        cpu_n_reset;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic [31:0] dbg_di = 32'h0;

    dbg_uart_loader #(
        .HOLD_AT_RESET (1),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK        (clk),
        .RESET      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .cpu_n_reset(cpu_n_reset),
        .dbg_mem_op (dbg_mem_op),
        .dbg_wren   (dbg_wren),
        .dbg_adr    (dbg_adr),
        .dbg_do     (dbg_do),
        .dbg_di     (dbg_di)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] adr;
        logic [31:0] data;
    } mem_ev_t;

    logic [7:0]  exp_tx[$];
    mem_ev_t     exp_mem[$];
    logic [31:0] tb_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic        ref_cpu = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          ready_mode = 0;

    function automatic logic [31:0] default_word(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return default_word(a);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic report_unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %h expected nothing at %0t", name, act, $time);
    endtask

    // Synchronous memory behind the debug port; read data lags the address by one cycle.
    always @(posedge clk) begin
        dbg_di <= tb_mem.exists(dbg_adr) ? tb_mem[dbg_adr] : default_word(dbg_adr);
        if (dbg_mem_op && dbg_wren == 4'hF) tb_mem[dbg_adr] = dbg_do;
    end

    // Transmitter model: ready pattern chosen by the stimulus process.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tx_ready = ($urandom_range(0, 3) != 0);
            1:       tx_ready = 1'b0;
            default: tx_ready = 1'b1;
        endcase
    end

    bit         stalled = 0;
    logic [7:0] stall_data = 8'h00;

    // Monitor: compares every handshake, held byte and memory cycle with the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check_output("tx_hold_valid", 32'(tx_valid), 32'd1);
                check_output("tx_hold_data", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) report_unexpected("unexpected_tx", 32'(tx_data));
                else check_output("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            stalled    = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (dbg_mem_op) begin
                if (exp_mem.size() == 0) begin
                    report_unexpected("unexpected_mem", dbg_adr);
                end else begin
                    mem_ev_t e;
                    e = exp_mem.pop_front();
                    check_output("mem_wren", 32'(dbg_wren), e.is_wr ? 32'hF : 32'h0);
                    check_output("mem_adr", dbg_adr, e.adr);
                    if (e.is_wr) check_output("mem_do", dbg_do, e.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_tx.size() != 0 || exp_mem.size() != 0 || tx_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) report_unexpected("wait_idle_timeout", 32'(exp_tx.size() + exp_mem.size()));
    endtask

    task automatic issue_write(input logic [31:0] a, input logic [31:0] d);
        mem_ev_t e;
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 3; i++) send_byte(d[8*i +: 8]);
        e.is_wr = 1; e.adr = a; e.data = d;
        exp_mem.push_back(e);
        exp_tx.push_back(8'h4B);
        ref_mem[a] = d;
        send_byte(d[31:24]);
    endtask

    task automatic issue_read(input logic [31:0] a);
        mem_ev_t     e;
        logic [31:0] w;
        send_byte(8'h52);
        for (int i = 0; i < 3; i++) send_byte(a[8*i +: 8]);
        w = ref_read(a);
        e.is_wr = 0; e.adr = a; e.data = 32'h0;
        exp_mem.push_back(e);
        exp_mem.push_back(e);
        for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
        send_byte(a[31:24]);
    endtask

    task automatic apply_stimulus_run(input logic [7:0] b);
        send_byte(b);
        if (b == 8'h47) ref_cpu = 1'b1;
        if (b == 8'h48) ref_cpu = 1'b0;
        @(negedge clk);
        check_output("cpu_n_reset", 32'(cpu_n_reset), 32'(ref_cpu));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_output("rst_tx_data", 32'(tx_data), 32'd0);
        check_output("rst_mem_op", 32'(dbg_mem_op), 32'd0);
        check_output("rst_wren", 32'(dbg_wren), 32'd0);
        check_output("rst_adr", dbg_adr, 32'd0);
        check_output("rst_do", dbg_do, 32'd0);
        check_output("rst_cpu", 32'(cpu_n_reset), 32'd0);
        ref_cpu = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0]  junk;
        logic [31:0] a;
        tb_mem[32'h0002_0004]  = 32'h0550_0593;
        ref_mem[32'h0002_0004] = 32'h0550_0593;
        repeat (2) @(negedge clk);
        pulse_reset();
        check_output("cpu_after_reset", 32'(cpu_n_reset), 32'd0);

        // Directed write then read of the reference words.
        issue_write(32'h0002_0000, 32'h0001_0537);
        wait_idle();
        issue_read(32'h0002_0004);
        wait_idle();

        // Run control and ignored byte.
        apply_stimulus_run(8'h47);
        apply_stimulus_run(8'h48);
        apply_stimulus_run(8'h47);
        apply_stimulus_run(8'hFF);

        // Backpressure: hold ready low for 10 cycles while a reply is pending.
        ready_mode = 1;
        issue_read(32'h0002_0000);
        for (int n = 0; n < 100 && !tx_valid; n++) @(negedge clk);
        check_output("bp_tx_valid", 32'(tx_valid), 32'd1);
        repeat (10) @(negedge clk);
        ready_mode = 2;
        wait_idle();
        ready_mode = 0;

        // Timeout in the middle of a write command.
        send_byte(8'h57);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TIMEOUT + 1) @(negedge clk);
        apply_stimulus_run(8'h48);
        issue_read(32'h0000_2211);
        wait_idle();

        // Reset after the sixth byte of a write.
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        send_byte(8'h99);
        pulse_reset();
        issue_write(32'h0002_0008, 32'hDEAD_BEEF);
        wait_idle();
        issue_read(32'h0002_0008);
        wait_idle();

        // Randomized command mix.
        for (int k = 0; k < 40; k++) begin
            a = 32'h0002_0000 + 32'($urandom_range(0, 7) << 2);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin issue_write(a, $urandom); wait_idle(); end
                4, 5, 6, 7: begin issue_read(a); wait_idle(); end
                8:          apply_stimulus_run($urandom_range(0, 1) ? 8'h47 : 8'h48);
                default: begin
                    junk = 8'($urandom);
                    while (junk == 8'h57 || junk == 8'h52 || junk == 8'h47 || junk == 8'h48)
                        junk = 8'($urandom);
                    apply_stimulus_run(junk);
                end
            endcase
        end

        repeat (5) @(negedge clk);
        check_output("leftover_tx", 32'(exp_tx.size()), 32'd0);
        check_output("leftover_mem", 32'(exp_mem.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
